pixel_write_buffer: RTL

Downstream stage of the line rasteriser. It consumes the rasteriser's per-pixel plot/x/y stream and its end-of-line done pulse, clips off-screen pixels, and converts (x,y) to a linear framebuffer address. It buffers writes in a small FIFO, because the rasteriser has no backpressure input. The FIFO drains to the framebuffer memory port through a req/ack handshake and reports when every pixel of a line has been committed.

---
 rtl/pixel_write_buffer_if.sv | 32 +++
 rtl/pixel_write_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer_if.sv
// ---------------------------------------------------------------------------
// pixel_write_buffer_if
// Framebuffer write port: single-entry request/acknowledge handshake.
//   mem_req   : write request, high while the write buffer holds an entry
//   mem_addr  : linear framebuffer address of the head entry
//   mem_wdata : pixel colour of the head entry
//   mem_ack   : memory accepts the head entry when mem_req & mem_ack
// master = write buffer side, slave = memory side.
// ---------------------------------------------------------------------------
interface pixel_write_buffer_if #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_wdata;
    logic               mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/pixel_write_buffer.sv
// ---------------------------------------------------------------------------
// pixel_write_buffer
// Sits behind the line rasteriser. Clips off-screen pixels, converts (x,y)
// to a linear framebuffer address and buffers the writes in a small
// first-word-fall-through FIFO that drains over a req/ack port. Tracks the
// rasteriser's end-of-line pulse and reports when the line is committed.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   plot_i           : pixel strobe, one cycle per pixel
//   x_i, y_i         : pixel column / row
//   color_i          : pixel colour, sampled with plot_i
//   line_done_i      : end-of-line pulse
//   mem              : framebuffer write port (master side)
//   busy_o           : pixels or an end-of-line still in flight
//   drained_o        : one-cycle pulse, last pixel of the line committed
//   overflow_o       : sticky, a pixel was dropped on a full FIFO
//   clip_count_o     : saturating count of clipped pixels
//   clear_status_i   : clears overflow_o and clip_count_o
// ---------------------------------------------------------------------------
module pixel_write_buffer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                plot_i,
    input  logic [10:0]         x_i,
    input  logic [10:0]         y_i,
    input  logic [COLOR_W-1:0]  color_i,
    input  logic                line_done_i,
    pixel_write_buffer_if.master mem,
    output logic                busy_o,
    output logic                drained_o,
    output logic                overflow_o,
    output logic [15:0]         clip_count_o,
    input  logic                clear_status_i
);
    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          MUL_W   = ADDR_W + 11;
    localparam logic [31:0] H_RES_U = 32'(H_RES);
    localparam logic [31:0] V_RES_U = 32'(V_RES);

    // Stage 1: capture register
    logic               stage_valid_q;
    logic               stage_done_q;
    logic [ADDR_W-1:0]  stage_addr_q;
    logic [COLOR_W-1:0] stage_color_q;

    // FIFO: pointers carry one extra wrap bit
    logic [ADDR_W-1:0]  fifo_addr_q  [DEPTH];
    logic [COLOR_W-1:0] fifo_color_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

    logic               pend_q, pend_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        clip_count_q, clip_count_d;

    logic in_range, clip_hit;
    logic fifo_empty, fifo_full;
    logic push, pop, drop;

    assign in_range = ({21'd0, x_i} < H_RES_U) && ({21'd0, y_i} < V_RES_U);
    assign clip_hit = plot_i & ~in_range;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pop  = ~fifo_empty & mem.mem_ack;
    // A full FIFO still accepts the push when the head retires in the same cycle.
    assign push = stage_valid_q & (~fifo_full | pop);
    assign drop = stage_valid_q & fifo_full & ~pop;

    assign mem.mem_req   = ~fifo_empty;
    assign mem.mem_addr  = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
    assign mem.mem_wdata = fifo_empty ? '0 : fifo_color_q[rd_ptr_q[PTR_W-1:0]];

    // pop cannot occur on an empty FIFO, so emptiness also covers "no pop".
    assign drained_o    = pend_q & fifo_empty & ~stage_valid_q;
    assign busy_o       = stage_valid_q | stage_done_q | ~fifo_empty | (pend_q & ~drained_o);
    assign overflow_o   = overflow_q;
    assign clip_count_o = clip_count_q;

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        // A done reaching stage 2 wins over a same-cycle drain of the previous line.
        pend_d = pend_q;
        if (stage_done_q)
            pend_d = 1'b1;
        else if (drained_o)
            pend_d = 1'b0;

        overflow_d = overflow_q;
        if (clear_status_i)
            overflow_d = 1'b0;
        else if (drop)
            overflow_d = 1'b1;

        clip_count_d = clip_count_q;
        if (clear_status_i)
            clip_count_d = '0;
        else if (clip_hit && clip_count_q != 16'hFFFF)
            clip_count_d = clip_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_done_q  <= 1'b0;
            stage_addr_q  <= '0;
            stage_color_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pend_q        <= 1'b0;
            overflow_q    <= 1'b0;
            clip_count_q  <= '0;
        end else begin
            stage_valid_q <= plot_i & in_range;
            stage_done_q  <= line_done_i;
            if (plot_i && in_range) begin
                stage_addr_q  <= ADDR_W'(MUL_W'(y_i) * MUL_W'(H_RES_U) + MUL_W'(x_i));
                stage_color_q <= color_i;
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pend_q        <= pend_d;
            overflow_q    <= overflow_d;
            clip_count_q  <= clip_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[PTR_W-1:0]]  <= stage_addr_q;
            fifo_color_q[wr_ptr_q[PTR_W-1:0]] <= stage_color_q;
        end
    end
endmodule
